// File: rtl/upg_boot_ctrl_pkg.sv
// Shared definitions for the boot/programming controller: state codes, zero word, default width.
package upg_boot_ctrl_pkg;
  localparam int          DEF_ADDR_W = 14;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } boot_state_e;
endpackage

// File: rtl/upg_boot_ctrl_boot_hold_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module boot_hold_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/upg_boot_ctrl.sv
// Boot controller sharing imem/dmem between the UART programmer and the CPU.
// Optional macro UPG_CHECKSUM_EN adds load_csum, a running sum of loaded words.
module upg_boot_ctrl
  import upg_boot_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upg_rst_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W:0]   upg_adr_i,
  input  logic [31:0]       upg_dat_i,
  input  logic              upg_done_i,
  input  logic [ADDR_W-1:0] cpu_pc_addr,
  input  logic [ADDR_W-1:0] cpu_dm_addr,
  input  logic              cpu_dm_we,
  input  logic [31:0]       cpu_dm_wdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              cpu_rst,
  output logic              inited,
  output logic              load_abort,
  output logic [ADDR_W:0]   imem_words,
  output logic [ADDR_W:0]   dmem_words,
`ifdef UPG_CHECKSUM_EN
  output logic [31:0]       load_csum,
`endif
  output logic [1:0]        state_o
);
  localparam int            HCW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  boot_state_e       state;
  logic              hold_done;
  logic              pipe_vld, pipe_dm;
  logic [ADDR_W-1:0] pipe_addr;
  logic [31:0]       pipe_data;

  wire prg_req    = !upg_rst_i && !upg_done_i;
  wire accept     = (state == LOAD) && upg_wen_i;
  wire load_enter = ((state == BOOT) || (state == RUN)) && prg_req;

  // Timer reloads whenever we are outside HOLD, so it holds HOLD_CYCLES-1 on entry.
  boot_hold_timer #(.W(HCW)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (state != HOLD),
    .load_val (HCW'(HOLD_CYCLES - 1)),
    .done     (hold_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      cpu_rst    <= 1'b1;
      inited     <= 1'b0;
      load_abort <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= prg_req ? LOAD : HOLD;
        LOAD: begin
          if (upg_done_i) begin
            state      <= HOLD;
            load_abort <= 1'b0;
          end else if (upg_rst_i) begin
            state      <= HOLD;
            load_abort <= 1'b1;
          end
        end
        HOLD: if (hold_done) begin
          state   <= RUN;
          cpu_rst <= 1'b0;
          inited  <= 1'b1;
        end
        RUN: if (prg_req) begin
          state   <= LOAD;
          cpu_rst <= 1'b1;
          inited  <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Write pipe: a word accepted on the LOAD exit edge still drains in the first HOLD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld  <= 1'b0;
      pipe_dm   <= 1'b0;
      pipe_addr <= '0;
      pipe_data <= ZERO_WORD;
    end else begin
      pipe_vld <= accept;
      if (accept) begin
        pipe_dm   <= upg_adr_i[ADDR_W];
        pipe_addr <= upg_adr_i[ADDR_W-1:0];
        pipe_data <= upg_dat_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_words <= '0;
      dmem_words <= '0;
    end else if (load_enter) begin
      imem_words <= '0;
      dmem_words <= '0;
    end else if (accept) begin
      if (upg_adr_i[ADDR_W]) begin
        if (dmem_words != WORDS_MAX) dmem_words <= dmem_words + 1'b1;
      end else begin
        if (imem_words != WORDS_MAX) imem_words <= imem_words + 1'b1;
      end
    end
  end

`ifdef UPG_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           load_csum <= ZERO_WORD;
    else if (load_enter) load_csum <= ZERO_WORD;
    else if (accept)     load_csum <= load_csum + upg_dat_i;
  end
`else
`endif

  always_comb begin
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = ZERO_WORD;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = ZERO_WORD;
    if (pipe_vld) begin
      if (pipe_dm) begin
        dmem_we    = 1'b1;
        dmem_addr  = pipe_addr;
        dmem_wdata = pipe_data;
      end else begin
        imem_we    = 1'b1;
        imem_addr  = pipe_addr;
        imem_wdata = pipe_data;
      end
    end else if (state == RUN) begin
      imem_addr  = cpu_pc_addr;
      dmem_we    = cpu_dm_we;
      dmem_addr  = cpu_dm_addr;
      dmem_wdata = cpu_dm_wdata;
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_upg_boot_ctrl.sv
// Scoreboard bench for upg_boot_ctrl: stimulus queues expected memory writes, a monitor checks them.
module tb_upg_boot_ctrl;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          upg_rst_i, upg_wen_i, upg_done_i;
  logic [AW:0]   upg_adr_i;
  logic [31:0]   upg_dat_i;
  logic [AW-1:0] cpu_pc_addr, cpu_dm_addr;
  logic          cpu_dm_we;
  logic [31:0]   cpu_dm_wdata;
  logic          imem_we, dmem_we, cpu_rst, inited, load_abort;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_wdata, dmem_wdata;
  logic [AW:0]   imem_words, dmem_words;
  logic [1:0]    state_o;
`ifdef UPG_CHECKSUM_EN
  logic [31:0]   load_csum;
`endif

  upg_boot_ctrl dut (
    .clk(clk), .reset(reset),
    .upg_rst_i(upg_rst_i), .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i),
    .upg_dat_i(upg_dat_i), .upg_done_i(upg_done_i),
    .cpu_pc_addr(cpu_pc_addr), .cpu_dm_addr(cpu_dm_addr),
    .cpu_dm_we(cpu_dm_we), .cpu_dm_wdata(cpu_dm_wdata),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .cpu_rst(cpu_rst), .inited(inited), .load_abort(load_abort),
    .imem_words(imem_words), .dmem_words(dmem_words),
`ifdef UPG_CHECKSUM_EN
    .load_csum(load_csum),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          dm;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every write strobe must match the oldest queued expectation, in the right cycle.
  always @(negedge clk) begin
    if (imem_we || dmem_we) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: imem_we=%b dmem_we=%b imem_addr=%h dmem_addr=%h expected none",
                 imem_we, dmem_we, imem_addr, dmem_addr);
      end else begin
        e = q.pop_front();
        chk("wr_dm_sel", {31'd0, dmem_we}, {31'd0, e.dm});
        chk("wr_im_sel", {31'd0, imem_we}, {31'd0, !e.dm});
        chk("wr_addr", {18'd0, e.dm ? dmem_addr : imem_addr}, {18'd0, e.addr});
        chk("wr_data", e.dm ? dmem_wdata : imem_wdata, e.data);
        chk("wr_cycle", cyc, e.at);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dm, input logic [AW-1:0] a, input logic [31:0] d, input int at);
    exp_t x;
    x.dm = dm; x.addr = a; x.data = d; x.at = at;
    q.push_back(x);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick;
    tick;
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_inited", {31'd0, inited}, 32'd0);
    chk("rst_abort", {31'd0, load_abort}, 32'd0);
    chk("rst_imem_words", {17'd0, imem_words}, 32'd0);
    chk("rst_dmem_words", {17'd0, dmem_words}, 32'd0);
    chk("rst_we", {30'd0, imem_we, dmem_we}, 32'd0);
    reset = 1'b0;
  endtask

  logic [AW:0]  t_adr [4];
  logic [31:0]  t_dat [4];

  initial begin
    reset = 1'b1;
    upg_rst_i = 1'b1; upg_wen_i = 1'b0; upg_done_i = 1'b0;
    upg_adr_i = '0; upg_dat_i = '0;
    cpu_pc_addr = 14'h0010; cpu_dm_addr = '0; cpu_dm_we = 1'b0; cpu_dm_wdata = '0;

    // Programmer inactive: BOOT -> HOLD x4 -> RUN, inited on the 5th edge.
    apply_reset;
    chk("boot_imem_addr", {18'd0, imem_addr}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (i == 1) chk("boot_to_hold", {30'd0, state_o}, 32'd2);
      chk($sformatf("inited_edge%0d", i), {31'd0, inited}, {31'd0, (i == 5)});
    end
    chk("run_state", {30'd0, state_o}, 32'd3);
    chk("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("run_pc_mux", {18'd0, imem_addr}, 32'h10);

    // CPU data write passes through with zero latency in RUN.
    cpu_dm_addr = 14'h0022; cpu_dm_wdata = 32'h1234_5678; cpu_dm_we = 1'b1;
    push(1'b1, 14'h0022, 32'h1234_5678, cyc);
    tick;
    cpu_dm_we = 1'b0;
    upg_rst_i = 1'b0;
    tick;
    chk("reprog_state", {30'd0, state_o}, 32'd1);
    chk("reprog_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reprog_inited", {31'd0, inited}, 32'd0);
    cpu_dm_addr = 14'h0023; cpu_dm_we = 1'b1;
    #1;
    chk("load_cpu_dm_blocked", {31'd0, dmem_we}, 32'd0);
    cpu_dm_we = 1'b0;

    // Abort with a write on the exit edge: it drains in the first HOLD cycle.
    upg_wen_i = 1'b1; upg_adr_i = 15'h0007; upg_dat_i = 32'hA5A5_0007; upg_rst_i = 1'b1;
    push(1'b0, 14'h0007, 32'hA5A5_0007, cyc + 1);
    tick;
    upg_wen_i = 1'b0;
    chk("abort_state", {30'd0, state_o}, 32'd2);
    chk("abort_flag", {31'd0, load_abort}, 32'd1);
    chk("abort_imem_words", {17'd0, imem_words}, 32'd1);
    chk("abort_dmem_words", {17'd0, dmem_words}, 32'd0);
    tick; tick; tick;
    chk("abort_still_hold", {30'd0, state_o}, 32'd2);
    tick;
    chk("abort_run", {30'd0, state_o}, 32'd3);
    chk("abort_inited", {31'd0, inited}, 32'd1);

    // Full load: three imem words then a dmem word coinciding with done.
    reset = 1'b1;
    upg_rst_i = 1'b0; upg_done_i = 1'b0;
    apply_reset;
    tick;
    chk("load_entry", {30'd0, state_o}, 32'd1);
    t_adr[0] = 15'h0000; t_dat[0] = 32'h2008_0001;
    t_adr[1] = 15'h0001; t_dat[1] = 32'h2009_0002;
    t_adr[2] = 15'h0002; t_dat[2] = 32'h0109_5020;
    t_adr[3] = 15'h4005; t_dat[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      upg_wen_i = 1'b1; upg_adr_i = t_adr[i]; upg_dat_i = t_dat[i];
      upg_done_i = (i == 3);
      push(t_adr[i][AW], t_adr[i][AW-1:0], t_dat[i], cyc + 1);
      tick;
    end
    upg_wen_i = 1'b0;
    chk("done_state", {30'd0, state_o}, 32'd2);
    chk("done_imem_words", {17'd0, imem_words}, 32'd3);
    chk("done_dmem_words", {17'd0, dmem_words}, 32'd1);
    chk("done_abort", {31'd0, load_abort}, 32'd0);
    tick; tick; tick; tick;
    chk("done_run", {30'd0, state_o}, 32'd3);
    chk("done_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Checksum wrap, then async reset with a write still in the pipe.
    reset = 1'b1;
    upg_done_i = 1'b0;
    apply_reset;
    tick;
    chk("load2_entry", {30'd0, state_o}, 32'd1);
    upg_wen_i = 1'b1; upg_adr_i = 15'h0010; upg_dat_i = 32'hFFFF_FFFF;
    push(1'b0, 14'h0010, 32'hFFFF_FFFF, cyc + 1);
    tick;
    upg_adr_i = 15'h0011; upg_dat_i = 32'h0000_0002;
    push(1'b0, 14'h0011, 32'h0000_0002, cyc + 1);
    tick;
    upg_adr_i = 15'h0012; upg_dat_i = 32'h0000_0055;
    chk("load2_imem_words", {17'd0, imem_words}, 32'd2);
`ifdef UPG_CHECKSUM_EN
    chk("csum_wrap", load_csum, 32'h0000_0001);
`endif
    tick;
    #2 reset = 1'b1;
    #1;
    chk("async_state", {30'd0, state_o}, 32'd0);
    chk("async_we_discard", {30'd0, imem_we, dmem_we}, 32'd0);
    chk("async_words", {17'd0, imem_words}, 32'd0);
`ifdef UPG_CHECKSUM_EN
    chk("async_csum", load_csum, 32'd0);
`endif
    upg_wen_i = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick; tick;
    chk("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
